// File: rtl/lru_way_age_tracker.sv
// Way-side end of the LRU eviction interface: keeps this way's age, runs its
// INVALID/VALID/EVICTING line-state FSM and latches protocol violations.
module lru_way_age_tracker #(
  parameter int NUM_WAYS  = 512,
  parameter int WAY_INDEX = 0
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                accessed,
  input  logic [$clog2(NUM_WAYS)-1:0]         accessedWayAge,
  output logic [$clog2(NUM_WAYS)-1:0]         myAge,
  output logic                                expired,
  input  logic                                fillReq,
  input  logic                                invalidateReq,
  input  logic                                evictGrant,
  input  logic                                evictDone,
  output logic                                wayValid,
  output logic                                evicting,
  output logic                                protocolError
);

  localparam int COUNTER_WIDTH = $clog2(NUM_WAYS);
  localparam logic [COUNTER_WIDTH-1:0] MAX_AGE   = COUNTER_WIDTH'(NUM_WAYS - 1);
  localparam logic [COUNTER_WIDTH-1:0] RESET_AGE = COUNTER_WIDTH'(WAY_INDEX);

  typedef enum logic [1:0] {
    ST_INVALID  = 2'd0,
    ST_VALID    = 2'd1,
    ST_EVICTING = 2'd2
  } state_e;

  logic [COUNTER_WIDTH-1:0] age_q, age_d;
  state_e                   state_q, state_d;
  logic                     err_q, err_d;
  logic                     violation;

  assign expired = (age_q == MAX_AGE);

  // Ageing runs in every FSM state so the set's ages always stay a permutation.
  always_comb begin
    age_d = age_q;
    if (accessed) begin
      age_d = '0;
    end else if (age_q < accessedWayAge) begin
      age_d = age_q + COUNTER_WIDTH'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    violation = 1'b0;
    if (accessed && (accessedWayAge != age_q)) begin
      violation = 1'b1;
    end
    if (evictDone && (state_q != ST_EVICTING)) begin
      violation = 1'b1;
    end
    case (state_q)
      ST_INVALID: begin
        if (fillReq) begin
          state_d = ST_VALID;
        end
        if (evictGrant) begin
          violation = 1'b1;
        end
      end
      ST_VALID: begin
        if (invalidateReq) begin
          state_d = ST_INVALID;
        end else if (evictGrant) begin
          if (expired) begin
            state_d = ST_EVICTING;
          end else begin
            violation = 1'b1;
          end
        end else if (fillReq) begin
          // Overwriting a live line without evicting it first.
          violation = 1'b1;
        end
      end
      ST_EVICTING: begin
        if (fillReq) begin
          state_d = ST_VALID;
        end else if (evictDone) begin
          state_d = ST_INVALID;
        end
        if (accessed || evictGrant) begin
          violation = 1'b1;
        end
      end
      default: begin
        state_d = ST_INVALID;
      end
    endcase
    err_d = err_q | violation;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      age_q   <= RESET_AGE;
      state_q <= ST_INVALID;
      err_q   <= 1'b0;
    end else begin
      age_q   <= age_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign myAge         = age_q;
  assign wayValid      = (state_q == ST_VALID);
  assign evicting      = (state_q == ST_EVICTING);
  assign protocolError = err_q;

endmodule

// File: tb/tb_lru_way_age_tracker.sv
// Scoreboard bench for lru_way_age_tracker (NUM_WAYS=4, WAY_INDEX=2): stimulus
// queues hand-computed expectations, a negedge monitor pops and compares them.
module tb_lru_way_age_tracker;

  logic       clk;
  logic       reset_n;
  logic       accessed;
  logic [1:0] accessedWayAge;
  logic [1:0] myAge;
  logic       expired;
  logic       fillReq;
  logic       invalidateReq;
  logic       evictGrant;
  logic       evictDone;
  logic       wayValid;
  logic       evicting;
  logic       protocolError;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  int         q_cyc[$];
  logic [5:0] q_exp[$];
  string      q_name[$];

  lru_way_age_tracker #(.NUM_WAYS(4), .WAY_INDEX(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .accessed      (accessed),
    .accessedWayAge(accessedWayAge),
    .myAge         (myAge),
    .expired       (expired),
    .fillReq       (fillReq),
    .invalidateReq (invalidateReq),
    .evictGrant    (evictGrant),
    .evictDone     (evictDone),
    .wayValid      (wayValid),
    .evicting      (evicting),
    .protocolError (protocolError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: the DUT presents its outputs every cycle; compare the entry due now.
  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      logic [5:0] exp_v;
      logic [5:0] act_v;
      string      nm;
      int         due;
      due   = q_cyc.pop_front();
      exp_v = q_exp.pop_front();
      nm    = q_name.pop_front();
      act_v = {myAge, expired, wayValid, evicting, protocolError};
      n_checks++;
      if (due != cyc) begin
        n_fails++;
        $display("FAIL %s: sampled at cycle %0d, required cycle %0d", nm, cyc, due);
      end else if (act_v !== exp_v) begin
        n_fails++;
        $display("FAIL %s: got age=%0d expired=%0b valid=%0b evicting=%0b err=%0b, want age=%0d expired=%0b valid=%0b evicting=%0b err=%0b",
                 nm, act_v[5:4], act_v[3], act_v[2], act_v[1], act_v[0],
                 exp_v[5:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input string nm, input bit acc, input logic [1:0] awa,
                      input bit fill, input bit inv, input bit grant, input bit done,
                      input bit rstn, input logic [1:0] e_age, input bit e_val,
                      input bit e_evi, input bit e_err);
    @(posedge clk);
    #1;
    reset_n        = rstn;
    accessed       = acc;
    accessedWayAge = awa;
    fillReq        = fill;
    invalidateReq  = inv;
    evictGrant     = grant;
    evictDone      = done;
    q_cyc.push_back(cyc + 1);
    q_exp.push_back({e_age, (e_age == 2'd3), e_val, e_evi, e_err});
    q_name.push_back(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; accessed = 1'b0; accessedWayAge = 2'd0;
    fillReq = 1'b0; invalidateReq = 1'b0; evictGrant = 1'b0; evictDone = 1'b0;

    //   name               acc awa fill inv grt done rstn  age val evi err
    step("reset",           0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0);
    step("age_up_to_3",     0, 3, 0, 0, 0, 0, 1,  3, 0, 0, 0);
    step("age_hold_3",      0, 1, 0, 0, 0, 0, 1,  3, 0, 0, 0);
    step("access_to_mru",   1, 3, 0, 0, 0, 0, 1,  0, 0, 0, 0);
    step("mru_bcast_hold",  0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0);

    step("fill_valid",      1, 0, 1, 0, 0, 0, 1,  0, 1, 0, 0);
    step("age_1",           0, 1, 0, 0, 0, 0, 1,  1, 1, 0, 0);
    step("age_2",           0, 2, 0, 0, 0, 0, 1,  2, 1, 0, 0);
    step("age_3",           0, 3, 0, 0, 0, 0, 1,  3, 1, 0, 0);
    step("grant_evicting",  0, 0, 0, 0, 1, 0, 1,  3, 0, 1, 0);
    step("done_invalid",    0, 0, 0, 0, 0, 1, 1,  3, 0, 0, 0);

    step("refill_valid",    1, 3, 1, 0, 0, 0, 1,  0, 1, 0, 0);
    step("age_1b",          0, 1, 0, 0, 0, 0, 1,  1, 1, 0, 0);
    step("age_2b",          0, 2, 0, 0, 0, 0, 1,  2, 1, 0, 0);
    step("age_3b",          0, 3, 0, 0, 0, 0, 1,  3, 1, 0, 0);
    step("grant_evict_b",   0, 0, 0, 0, 1, 0, 1,  3, 0, 1, 0);
    step("fill_from_evict", 0, 0, 1, 0, 0, 0, 1,  3, 1, 0, 0);

    step("inv_beats_grant", 0, 0, 0, 1, 1, 0, 1,  3, 0, 0, 0);
    step("fill_c",          1, 3, 1, 0, 0, 0, 1,  0, 1, 0, 0);
    step("age_1c",          0, 1, 0, 0, 0, 0, 1,  1, 1, 0, 0);
    step("age_2c",          0, 2, 0, 0, 0, 0, 1,  2, 1, 0, 0);
    step("age_3c",          0, 3, 0, 0, 0, 0, 1,  3, 1, 0, 0);
    step("grant_evict_c",   0, 0, 0, 0, 1, 0, 1,  3, 0, 1, 0);
    step("inv_ignored",     0, 0, 0, 1, 0, 0, 1,  3, 0, 1, 0);
    step("fill_beats_done", 0, 0, 1, 0, 0, 1, 1,  3, 1, 0, 0);

    step("access_d",        1, 3, 0, 0, 0, 0, 1,  0, 1, 0, 0);
    step("age_1d",          0, 1, 0, 0, 0, 0, 1,  1, 1, 0, 0);
    step("early_grant_err", 0, 0, 0, 0, 1, 0, 1,  1, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step("err_sticky",    0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 1);
    end

    step("reset_clear",     0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0);
    step("access_ok",       1, 2, 0, 0, 0, 0, 1,  0, 0, 0, 0);
    step("age_mismatch",    1, 2, 0, 0, 0, 0, 1,  0, 0, 0, 1);
    step("reset_again",     0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0);

    step("fill_e",          1, 2, 1, 0, 0, 0, 1,  0, 1, 0, 0);
    step("age_1e",          0, 1, 0, 0, 0, 0, 1,  1, 1, 0, 0);
    step("age_2e",          0, 2, 0, 0, 0, 0, 1,  2, 1, 0, 0);
    step("age_3e",          0, 3, 0, 0, 0, 0, 1,  3, 1, 0, 0);
    step("grant_evict_e",   0, 0, 0, 0, 1, 0, 1,  3, 0, 1, 0);
    step("reset_mid_evict", 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0);
    step("post_reset_idle", 0, 0, 0, 0, 0, 0, 1,  2, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (q_cyc.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q_cyc.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
